// File: rtl/fp_pkg.sv
// Shared types and helpers for the floating-point adder and its latency-matching buffer.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_t;

  localparam int GRS_W = 3;

  function automatic int fp_latency(input int save_ff);
    return (save_ff != 0) ? 1 : 7;
  endfunction

  // Canonical quiet NaN in the low exp_w+frac_w+1 bits: sign 0, exp all ones, frac MSB set.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int frac_w);
    logic [127:0] ones;
    ones = (128'd1 << exp_w) - 128'd1;
    return (ones << frac_w) | (128'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns W when the input is all zeros.
module fp_lzc #(
  parameter int W = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/floating_point_adder.sv
// Pipelined IEEE-754-style adder, round-to-nearest-even, subnormals flushed to zero.
module floating_point_adder
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int SAVE_FF    = 1,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] fp_a_i,
  input  logic [FP_WIDTH_REG-1:0] fp_b_i,
  input  logic                    valid_i,
  output logic [FP_WIDTH_REG-1:0] fp_o,
  output logic                    valid_o
);

  localparam int E   = EXP_WIDTH;
  localparam int F   = FRAC_WIDTH;
  localparam int FPW = FP_WIDTH_REG;
  localparam int M   = F + 1 + GRS_W;
  localparam int LZW = $clog2(M + 1);
  localparam int XW  = ((E > LZW) ? E : LZW) + 2;
  localparam int LAT = fp_latency(SAVE_FF);

  localparam logic [FPW-1:0]       QNAN   = FPW'(fp_qnan(E, F));
  localparam logic [E-1:0]         EMAX   = '1;
  localparam logic signed [XW-1:0] X_ZERO = '0;
  localparam logic signed [XW-1:0] X_ONE  = XW'(1);
  localparam logic signed [XW-1:0] X_EMAX = XW'(2 ** E - 1);

  typedef struct packed {
    logic      s;
    logic [E-1:0] e;
    logic [F:0]   m;
    fp_class_t c;
  } opnd_t;

  typedef struct packed { opnd_t a; opnd_t b; } st1_t;

  typedef struct packed {
    logic s; logic sub; logic [E-1:0] ex; logic [E-1:0] d;
    logic [F:0] mx; logic [F:0] my; logic spc; logic [FPW-1:0] sv;
  } st2_t;

  typedef struct packed {
    logic s; logic sub; logic [E-1:0] ex;
    logic [M-1:0] mx; logic [M-1:0] my; logic spc; logic [FPW-1:0] sv;
  } st3_t;

  typedef struct packed {
    logic s; logic [E-1:0] ex; logic [M:0] sum; logic spc; logic [FPW-1:0] sv;
  } st4_t;

  typedef struct packed {
    logic s; logic [E-1:0] ex; logic [M:0] sum; logic [LZW-1:0] lz;
    logic spc; logic [FPW-1:0] sv;
  } st5_t;

  typedef struct packed {
    logic s; logic [XW-1:0] e; logic [M-1:0] m; logic zero;
    logic spc; logic [FPW-1:0] sv;
  } st6_t;

  function automatic opnd_t unpack(input logic [FPW-1:0] w);
    opnd_t o;
    o.s = w[FPW-1];
    o.e = w[F +: E];
    o.m = {1'b1, w[F-1:0]};
    o.c = NORM;
    if (o.e == '0) begin
      o.e = '0;
      o.m = '0;
      o.c = ZERO;
    end else if (o.e == EMAX) begin
      o.c = (w[F-1:0] != '0) ? NAN : INF;
    end
    return o;
  endfunction

  // Round to nearest even, then resolve specials, zero, underflow and overflow.
  function automatic logic [FPW-1:0] round_pack(input st6_t t);
    logic                 up;
    logic [F+1:0]         mr;
    logic signed [XW-1:0] ef;
    logic [F-1:0]         frac;
    up   = t.m[2] & (t.m[1] | t.m[0] | t.m[3]);
    mr   = {1'b0, t.m[M-1:GRS_W]} + (F+2)'(up);
    ef   = $signed(t.e) + $signed(XW'(mr[F+1]));
    frac = mr[F+1] ? mr[F:1] : mr[F-1:0];
    if (t.spc)                   return t.sv;
    if (t.zero)                  return '0;
    if ($signed(t.e) <= X_ZERO)  return {t.s, {(FPW-1){1'b0}}};
    if (ef >= X_EMAX)            return {t.s, EMAX, {F{1'b0}}};
    return {t.s, ef[E-1:0], frac};
  endfunction

  st1_t st1_c, st1_p1;
  st2_t st2_c, st2_p2;
  st3_t st3_c, st3_p3;
  st4_t st4_c, st4_p4;
  st5_t st5_c, st5_p5;
  st6_t st6_c, st6_p6;
  logic [LZW-1:0] lz_c;
  logic [LAT-1:0] vld_p;

  // S1: unpack and classify
  always_comb begin
    st1_c.a = unpack(fp_a_i);
    st1_c.b = unpack(fp_b_i);
  end

  // S2: order by magnitude and resolve special operands
  always_comb begin
    opnd_t x, y;
    logic  a_big;
    a_big = {st1_p1.a.e, st1_p1.a.m} >= {st1_p1.b.e, st1_p1.b.m};
    x = a_big ? st1_p1.a : st1_p1.b;
    y = a_big ? st1_p1.b : st1_p1.a;
    st2_c.s   = x.s;
    st2_c.sub = x.s ^ y.s;
    st2_c.ex  = x.e;
    st2_c.d   = x.e - y.e;
    st2_c.mx  = x.m;
    st2_c.my  = y.m;
    st2_c.spc = 1'b1;
    st2_c.sv  = '0;
    if (st1_p1.a.c == NAN || st1_p1.b.c == NAN)
      st2_c.sv = QNAN;
    else if (st1_p1.a.c == INF && st1_p1.b.c == INF)
      st2_c.sv = (st1_p1.a.s != st1_p1.b.s) ? QNAN : {st1_p1.a.s, EMAX, {F{1'b0}}};
    else if (st1_p1.a.c == INF)
      st2_c.sv = {st1_p1.a.s, EMAX, {F{1'b0}}};
    else if (st1_p1.b.c == INF)
      st2_c.sv = {st1_p1.b.s, EMAX, {F{1'b0}}};
    else if (st1_p1.a.c == ZERO && st1_p1.b.c == ZERO)
      st2_c.sv = {st1_p1.a.s & st1_p1.b.s, {(FPW-1){1'b0}}};
    else
      st2_c.spc = 1'b0;
  end

  // S3: align the smaller operand, folding shifted-out bits into sticky
  always_comb begin
    logic [2*M-1:0] sh;
    sh = {st2_p2.my, {GRS_W{1'b0}}, {M{1'b0}}} >> st2_p2.d;
    st3_c.s   = st2_p2.s;
    st3_c.sub = st2_p2.sub;
    st3_c.ex  = st2_p2.ex;
    st3_c.mx  = {st2_p2.mx, {GRS_W{1'b0}}};
    st3_c.spc = st2_p2.spc;
    st3_c.sv  = st2_p2.sv;
    if (int'(st2_p2.d) >= F + GRS_W)
      st3_c.my = {{(M-1){1'b0}}, |st2_p2.my};
    else
      st3_c.my = {sh[2*M-1:M+1], sh[M] | (|sh[M-1:0])};
  end

  // S4: effective add or subtract
  always_comb begin
    st4_c.s   = st3_p3.s;
    st4_c.ex  = st3_p3.ex;
    st4_c.sum = st3_p3.sub ? ({1'b0, st3_p3.mx} - {1'b0, st3_p3.my})
                           : ({1'b0, st3_p3.mx} + {1'b0, st3_p3.my});
    st4_c.spc = st3_p3.spc;
    st4_c.sv  = st3_p3.sv;
  end

  // S5: leading-zero count below the carry bit
  fp_lzc #(.W(M)) u_lzc (
    .din (st4_p4.sum[M-1:0]),
    .cnt (lz_c)
  );

  always_comb begin
    st5_c.s   = st4_p4.s;
    st5_c.ex  = st4_p4.ex;
    st5_c.sum = st4_p4.sum;
    st5_c.lz  = lz_c;
    st5_c.spc = st4_p4.spc;
    st5_c.sv  = st4_p4.sv;
  end

  // S6: normalise
  always_comb begin
    logic signed [XW-1:0] ex_s, lz_s;
    ex_s = $signed(XW'(st5_p5.ex));
    lz_s = $signed(XW'(st5_p5.lz));
    st6_c.s    = st5_p5.s;
    st6_c.zero = (st5_p5.sum == '0);
    st6_c.spc  = st5_p5.spc;
    st6_c.sv   = st5_p5.sv;
    if (st5_p5.sum[M]) begin
      st6_c.e = ex_s + X_ONE;
      st6_c.m = {st5_p5.sum[M:2], st5_p5.sum[1] | st5_p5.sum[0]};
    end else begin
      st6_c.e = ex_s - lz_s;
      st6_c.m = st5_p5.sum[M-1:0] << st5_p5.lz;
    end
  end

  generate
    if (SAVE_FF == 0) begin : g_pipe
      always_ff @(posedge clk_i) begin
        st1_p1 <= st1_c;
        st2_p2 <= st2_c;
        st3_p3 <= st3_c;
        st4_p4 <= st4_c;
        st5_p5 <= st5_c;
        st6_p6 <= st6_c;
      end
    end else begin : g_flat
      always_comb begin
        st1_p1 = st1_c;
        st2_p2 = st2_c;
        st3_p3 = st3_c;
        st4_p4 = st4_c;
        st5_p5 = st5_c;
        st6_p6 = st6_c;
      end
    end
  endgenerate

  // S7: round and pack into the output register
  always_ff @(posedge clk_i) begin
    fp_o <= round_pack(st6_p6);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= valid_i;
      for (int k = 1; k < LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  assign valid_o = vld_p[LAT-1];

endmodule

// File: tb/tb_floating_point_adder.sv
// Directed and streamed checks of the FP32 adder for both pipeline depths side by side.
module tb_floating_point_adder;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic [31:0] a, b;
  logic [31:0] o0, o1;
  logic        v0, v1;

  logic        hv [N];
  logic [31:0] he [N];
  int          k;
  int          passed;
  int          fails;
  int          total;

  always #5 clk = ~clk;

  floating_point_adder #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .SAVE_FF(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .fp_a_i(a), .fp_b_i(b), .valid_i(vin),
    .fp_o(o0), .valid_o(v0)
  );

  floating_point_adder #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .SAVE_FF(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .fp_a_i(a), .fp_b_i(b), .valid_i(vin),
    .fp_o(o1), .valid_o(v1)
  );

  function automatic real f2r(input logic [31:0] x);
    logic [10:0] de;
    de = 11'(x[30:23]) + 11'd896;
    return $bitstoreal({x[31], de, x[22:0], 29'd0});
  endfunction

  // Exact double sum (operand exponents kept close), then one RNE rounding to FP32.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] r;
    logic        up;
    int          e;
    d = $realtobits(f2r(x) + f2r(y));
    if (d[62:0] == 63'd0) return 32'h0000_0000;
    e  = int'(d[62:52]) - 896;
    m  = {1'b1, d[51:0]};
    up = m[28] && ((m[27:0] != 28'd0) || m[29]);
    r  = {1'b0, m[52:29]} + 25'(up);
    if (r[24]) begin
      e++;
      r = r >> 1;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), r[22:0]};
  endfunction

  function automatic logic [31:0] rand_norm();
    return {1'($urandom), 8'($urandom_range(138, 112)), 23'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, k, obs, expv);
    end
  endtask

  task automatic check_dut(input string name, input int lat, input logic v, input logic [31:0] o);
    int   i;
    logic ev;
    i  = k - lat;
    ev = (i >= 0) ? hv[i] : 1'b0;
    chk({name, " valid_o"}, {31'd0, v}, {31'd0, ev});
    if (ev) chk({name, " fp_o"}, o, he[i]);
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] e);
    if (k >= N - 1) begin
      $display("FAIL history overflow at cycle %0d", k);
      $fatal(1);
    end
    rst = r; vin = v; a = x; b = y;
    hv[k] = v & ~r;
    he[k] = e;
    if (r) for (int j = 0; j <= k; j++) hv[j] = 1'b0;
    @(posedge clk);
    #1;
    k++;
    check_dut("lat7", 7, v0, o0);
    check_dut("lat1", 1, v1, o1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    step(1'b0, 1'b1, x, y, e);
  endtask

  initial begin
    logic [31:0] x, y;
    k = 0; passed = 0; fails = 0; total = 0;
    rst = 1'b1; vin = 1'b0; a = '0; b = '0;

    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    idle(2);

    vec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    idle(9);

    vec(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000); idle(2);
    vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000); idle(2);
    vec(32'h8000_0000, 32'h0000_0000, 32'h0000_0000); idle(2);
    vec(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000); idle(2);
    vec(32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001); idle(2);
    vec(32'h3FC0_0000, 32'hBFA0_0000, 32'h3E80_0000); idle(2);
    vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000); idle(2);
    vec(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000); idle(2);
    vec(32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000); idle(2);
    vec(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000); idle(2);
    vec(32'h0040_0000, 32'h3F80_0000, 32'h3F80_0000); idle(8);

    for (int i = 0; i < 20; i++) begin
      x = rand_norm();
      y = rand_norm();
      vec(x, y, ref_add(x, y));
      if (i % 4 == 3) idle(2);
    end
    idle(8);

    for (int i = 0; i < 4; i++) begin
      x = rand_norm();
      y = rand_norm();
      vec(x, y, ref_add(x, y));
    end
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    vec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
    idle(9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/floating_point_adder.md
Name: floating_point_adder

Overview:
- Pipelined IEEE-754-style adder for operands a and b. Format set by EXP_WIDTH/FRAC_WIDTH.
- Sits in the arithmetic datapath. Its sum output is consumed alongside operands that the floating_point_adder_z latency-matching buffer delays.
- Latency and valid behaviour match floating_point_adder_z exactly for the same SAVE_FF setting.
- Fully pipelined, one result per cycle, no backpressure.

Parameters:
- EXP_WIDTH, 8, exponent field width (>=2)
- FRAC_WIDTH, 23, stored fraction width (>=1)
- SAVE_FF, 1, 0 = 7-stage pipeline; 1 = single output register stage
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, local; total word width

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- fp_a_i  input  FP_WIDTH_REG  operand a {sign, exp, frac}
- fp_b_i  input  FP_WIDTH_REG  operand b
- valid_i  input  1  operands valid this cycle
- fp_o  output  FP_WIDTH_REG  sum a+b
- valid_o  output  1  fp_o valid this cycle

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high.
  - rst_i clears every valid register, so valid_o=0 in the cycle after reset is sampled and stays 0 until new valids propagate.
  - Data registers are not reset. fp_o is don't-care whenever valid_o=0.
  - Reset mid-operation: all in-flight valids are dropped. No partial result is ever flagged valid.
- Latency and throughput
  - SAVE_FF=0: 7 cycles. Input sampled at edge N appears at edge N+7.
  - SAVE_FF=1: 1 cycle. All datapath logic is combinational into the output register.
  - Throughput is 1 per cycle. Back-to-back valids produce back-to-back results. Bubbles are preserved.
- Stage split for SAVE_FF=0
  - S1: unpack, classify (zero/normal/inf/NaN); subnormal inputs flushed to signed zero.
  - S2: magnitude compare, swap so |x| >= |y|, compute exponent difference.
  - S3: align y by the exponent difference into a FRAC_WIDTH+4-bit mantissa with guard, round and sticky bits. Shifts >= FRAC_WIDTH+3 collapse to sticky only.
  - S4: add or subtract per effective operation (sign xor), keeping 1 carry bit.
  - S5: leading-zero count of the result.
  - S6: normalise. On carry, right shift 1 and exp+1 (sticky ORed). Otherwise left shift by the LZC and exp-LZC.
  - S7: round to nearest, ties to even, then pack. A rounding carry renormalises and increments the exponent.
- Special cases, checked in priority order
  - Any NaN input gives a canonical quiet NaN: sign 0, exp all ones, frac MSB 1, rest 0.
  - inf + -inf gives a canonical NaN.
  - inf + finite, or inf + same-sign inf, gives that inf.
  - Exact cancellation gives +0.
  - -0 + -0 gives -0. Any other zero + zero gives +0.
  - Exponent overflow after rounding gives signed inf.
  - Underflow (biased exp <= 0 after normalise) flushes to signed zero. No subnormal outputs.
- The valid shift register is independent of the data path. valid_o equals valid_i delayed by the latency, and is not gated by special cases.

Decomposition:
- Shared package fp_pkg
  - fp_class_t enum (ZERO, NORM, INF, NAN).
  - Function for the canonical quiet NaN given EXP_WIDTH/FRAC_WIDTH.
  - Function fp_latency(SAVE_FF) returning 7 or 1. floating_point_adder_z uses it too.
  - GRS width constant (3).
- Sub-module fp_lzc: parameterised combinational leading-zero counter, used in S5.

Test Plan (FP32: EXP_WIDTH=8, FRAC_WIDTH=23, both SAVE_FF values):
- 0x3F800000 + 0x40000000 with valid_i=1 for one cycle -> fp_o=0x40400000 with valid_o=1 exactly 7 cycles later (SAVE_FF=0) or 1 cycle later (SAVE_FF=1); valid_o=0 on all other cycles.
- 0x3F800000 + 0xBF800000 -> 0x00000000; 0x80000000 + 0x80000000 -> 0x80000000.
- Rounding: 0x3F800000 + 0x33800000 (tie) -> 0x3F800000; 0x3F800000 + 0x33C00000 -> 0x3F800001.
- Specials: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000; 0x7F800000 + 0xFF800000 -> 0x7FC00000; 0x7FA00000 + 0x3F800000 -> 0x7FC00000; 0x00400000 + 0x3F800000 -> 0x3F800000.
- Streaming: 20 back-to-back random normal pairs with a 2-cycle bubble pattern -> results in order, bubble pattern reproduced on valid_o, each compared bit-exact to a reference model.
- Reset mid-stream: assert rst_i for 1 cycle while 4 valids are in flight -> valid_o=0 for every cycle in which a pre-reset valid would have emerged; the first post-reset input emerges after the normal latency.
